io_hub_param: RTL and testbench

IO_HUB_PARAM -- requirements
Module: io_hub_param

---
 rtl/io_hub_param_pkg.sv | 46 ++++
 rtl/io_hub_param_if.sv | 11 +
 rtl/io_hub_param_btn_debounce.sv | 53 +++++
 rtl/io_hub_param.sv | 143 ++++++++++++++
 tb/tb_io_hub_param.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_hub_param_pkg.sv
// Shared register map and seven-segment encoding for the memory-mapped IO hub.
package io_hub_param_pkg;

  typedef enum logic [2:0] {
    REG_LED       = 3'd0,
    REG_SW        = 3'd1,
    REG_BTN_STATE = 3'd2,
    REG_BTN_EVENT = 3'd3,
    REG_IRQ_EN    = 3'd4,
    REG_SEG_DATA  = 3'd5,
    REG_SEG_MASK  = 3'd6,
    REG_RSVD      = 3'd7
  } reg_sel_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Returns active-low {dp, g, f, e, d, c, b, a} with the decimal point dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      default: lit = 7'h71;
    endcase
    return {1'b1, ~lit};
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_hub_param_if.sv
// Simple single-cycle register bus: combinational read data, write on the clock edge.
interface io_hub_param_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output ce, we, addr, wdata, input rdata);
  modport slave  (input ce, we, addr, wdata, output rdata);
endinterface

// File: rtl/io_hub_param_btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced state and rise pulse.
module btn_debounce
  import io_hub_param_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic state,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          flip;

  always_comb begin
    sync_d  = {sync_q[0], din};
    cnt_d   = cnt_q;
    state_d = state_q;
    flip    = 1'b0;
    if (sync_q[1] == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      // Last of DB_CYCLES consecutive differing clocks: accept the new level.
      flip    = 1'b1;
      cnt_d   = '0;
      state_d = ~state_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state = state_q;
  assign rise  = flip & ~state_q;

endmodule

// File: rtl/io_hub_param.sv
// Memory-mapped IO hub: LEDs, synchronised switches, debounced buttons with sticky
// events and interrupt, and a multiplexed seven-segment display scanner.
module io_hub_param
  import io_hub_param_pkg::*;
#(
  parameter int unsigned NUM_LED   = 16,
  parameter int unsigned NUM_SW    = 16,
  parameter int unsigned NUM_BTN   = 16,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic                clk,
  input  logic                rst,
  io_hub_param_if.slave       bus,
  output logic [NUM_LED-1:0]  led,
  input  logic [NUM_SW-1:0]   sw,
  input  logic [NUM_BTN-1:0]  btn,
  output logic [7:0]          seg_cat,
  output logic [DIGITS-1:0]   seg_an,
  output logic                irq
);

  localparam int unsigned DIV_W = cnt_width(SCAN_DIV);
  localparam int unsigned DIG_W = cnt_width(DIGITS);
  localparam int unsigned SEG_W = 4 * DIGITS;

  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
  logic [NUM_BTN-1:0] btn_event_q, btn_event_d;
  logic [SEG_W-1:0]   seg_data_q, seg_data_d;
  logic [DIGITS-1:0]  seg_mask_q, seg_mask_d;
  logic [NUM_SW-1:0]  sw_meta_q, sw_meta_d;
  logic [NUM_SW-1:0]  sw_sync_q, sw_sync_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIG_W-1:0]   digit_q, digit_d;

  logic [NUM_BTN-1:0] btn_state;
  logic [NUM_BTN-1:0] btn_rise;
  logic               wr_en;
  logic               rd_en;
  reg_sel_e           sel;
  logic               unused_bus_bits;

  assign wr_en = bus.ce & bus.we;
  assign rd_en = bus.ce & ~bus.we;
  assign sel   = reg_sel_e'(bus.addr[4:2]);
  assign unused_bus_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (btn[i]),
      .state (btn_state[i]),
      .rise  (btn_rise[i])
    );
  end

  always_comb begin
    led_d       = led_q;
    irq_en_d    = irq_en_q;
    btn_event_d = btn_event_q;
    seg_data_d  = seg_data_q;
    seg_mask_d  = seg_mask_q;
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;
    if (wr_en) begin
      case (sel)
        REG_LED:       led_d       = bus.wdata[NUM_LED-1:0];
        REG_BTN_EVENT: btn_event_d = btn_event_q & ~bus.wdata[NUM_BTN-1:0];
        REG_IRQ_EN:    irq_en_d    = bus.wdata[NUM_BTN-1:0];
        REG_SEG_DATA:  seg_data_d  = bus.wdata[SEG_W-1:0];
        REG_SEG_MASK:  seg_mask_d  = bus.wdata[DIGITS-1:0];
        default: ;
      endcase
    end
    // Applied after the clear so a same-cycle rise keeps its event bit.
    btn_event_d = btn_event_d | btn_rise;
  end

  always_comb begin
    bus.rdata = '0;
    if (rd_en) begin
      case (sel)
        REG_LED:       bus.rdata = 32'(led_q);
        REG_SW:        bus.rdata = 32'(sw_sync_q);
        REG_BTN_STATE: bus.rdata = 32'(btn_state);
        REG_BTN_EVENT: bus.rdata = 32'(btn_event_q);
        REG_IRQ_EN:    bus.rdata = 32'(irq_en_q);
        REG_SEG_DATA:  bus.rdata = 32'(seg_data_q);
        REG_SEG_MASK:  bus.rdata = 32'(seg_mask_q);
        default:       bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    div_d   = div_q + 1'b1;
    digit_d = digit_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d   = '0;
      digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  always_comb begin
    seg_an  = '1;
    seg_cat = SEG_BLANK;
    if (seg_mask_q[digit_q]) begin
      seg_an[digit_q] = 1'b0;
      seg_cat         = hex_to_seg(seg_data_q[{digit_q, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q       <= '0;
      irq_en_q    <= '0;
      btn_event_q <= '0;
      seg_data_q  <= '0;
      seg_mask_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      div_q       <= '0;
      digit_q     <= '0;
    end else begin
      led_q       <= led_d;
      irq_en_q    <= irq_en_d;
      btn_event_q <= btn_event_d;
      seg_data_q  <= seg_data_d;
      seg_mask_q  <= seg_mask_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      div_q       <= div_d;
      digit_q     <= digit_d;
    end
  end

  assign led = led_q;
  assign irq = |(btn_event_q & irq_en_q);

endmodule

// File: tb/tb_io_hub_param.sv
// Directed plus randomized bench for io_hub_param against a cycle-level behavioural model.
module tb_io_hub_param;

  localparam int unsigned DB = 4;
  localparam int unsigned SD = 3;
  localparam int unsigned ND = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] led;
  logic [15:0] sw;
  logic [15:0] btn;
  logic [7:0]  seg_cat;
  logic [3:0]  seg_an;
  logic        irq;

  io_hub_param_if bus ();

  io_hub_param #(
    .NUM_LED   (16),
    .NUM_SW    (16),
    .NUM_BTN   (16),
    .DIGITS    (ND),
    .DB_CYCLES (DB),
    .SCAN_DIV  (SD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .led     (led),
    .sw      (sw),
    .btn     (btn),
    .seg_cat (seg_cat),
    .seg_an  (seg_an),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural model state
  logic [15:0] m_led, m_ien, m_evt, m_bst, m_segd;
  logic [3:0]  m_segm;
  int unsigned m_cyc;
  logic [15:0] bh[$];  // raw button samples, one per clock edge
  logic [15:0] sh[$];  // raw switch samples, one per clock edge

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return {1'b1, ~p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_ien = '0; m_evt = '0; m_bst = '0; m_segd = '0; m_segm = '0;
    m_cyc = 0;
    bh.delete();
    repeat (DB + 2) bh.push_back(16'h0);
    sh.delete();
    repeat (2) sh.push_back(16'h0);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] s);
    case (s)
      3'd0: return 32'(m_led);
      3'd1: return 32'(sh[sh.size() - 2]);
      3'd2: return 32'(m_bst);
      3'd3: return 32'(m_evt);
      3'd4: return 32'(m_ien);
      3'd5: return 32'(m_segd);
      3'd6: return 32'(m_segm);
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge: a button level is accepted once the synchronised input
  // (two samples late) has disagreed with it for DB consecutive edges.
  task automatic model_edge();
    logic [2:0]  s;
    logic        wr_en;
    logic [15:0] rise;
    logic [15:0] clr;
    bit          flip;
    s     = bus.addr[4:2];
    wr_en = bus.ce && bus.we;
    bh.push_back(btn);
    sh.push_back(sw);
    if (bh.size() > 32) void'(bh.pop_front());
    if (sh.size() > 32) void'(sh.pop_front());
    rise = '0;
    for (int i = 0; i < 16; i++) begin
      flip = 1'b1;
      for (int j = 0; j < int'(DB); j++)
        if (bh[bh.size() - 3 - j][i] == m_bst[i]) flip = 1'b0;
      if (flip) begin
        rise[i]  = ~m_bst[i];
        m_bst[i] = ~m_bst[i];
      end
    end
    clr   = (wr_en && s == 3'd3) ? bus.wdata[15:0] : 16'h0;
    m_evt = (m_evt & ~clr) | rise;
    if (wr_en) begin
      case (s)
        3'd0: m_led  = bus.wdata[15:0];
        3'd4: m_ien  = bus.wdata[15:0];
        3'd5: m_segd = bus.wdata[15:0];
        3'd6: m_segm = bus.wdata[3:0];
        default: ;
      endcase
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    int unsigned dig;
    logic [3:0]  an;
    logic [7:0]  cat;
    dig = (m_cyc / SD) % ND;
    an  = 4'hF;
    cat = 8'hFF;
    if (m_segm[dig]) begin
      an[dig] = 1'b0;
      cat     = seg_code(m_segd[dig*4 +: 4]);
    end
    chk("led",     32'(led),     32'(m_led));
    chk("irq",     32'(irq),     32'(|(m_evt & m_ien)));
    chk("seg_an",  32'(seg_an),  32'(an));
    chk("seg_cat", 32'(seg_cat), 32'(cat));
    chk("rdata",   bus.rdata, (bus.ce && !bus.we) ? model_read(bus.addr[4:2]) : 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    step();
    d = bus.rdata;
    bus.ce = 1'b0;
  endtask

  function automatic logic [31:0] raddr(input logic [2:0] s);
    logic [31:0] r;
    r = $urandom;
    r[4:2] = s;
    return r;
  endfunction

  task automatic reset_now();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_led",     32'(led),     32'h0);
    chk("rst_irq",     32'(irq),     32'h0);
    chk("rst_seg_an",  32'(seg_an),  32'hF);
    chk("rst_seg_cat", 32'(seg_cat), 32'hFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int unsigned b;
    rst = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    btn = '0; sw = '0;

    @(negedge clk);
    reset_now();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int s = 0; s < 8; s++) rd(raddr(3'(s)), d);

    wr(32'h0000_0000, 32'h0000_A5A5);
    chk("led_a5a5", 32'(led), 32'h0000_A5A5);
    rd(32'h0000_0000, d);
    chk("rd_led_a5a5", d, 32'h0000_A5A5);

    repeat (24) begin
      if ($urandom_range(0, 1) == 0) wr(raddr(3'($urandom_range(0, 7))), $urandom);
      else rd(raddr(3'($urandom_range(0, 7))), d);
    end

    repeat (5) begin
      sw = 16'($urandom);
      idle(1);
      rd(raddr(3'd1), d);
      rd(raddr(3'd1), d);
    end

    wr(32'h10, 32'h0);
    wr(32'h0C, 32'hFFFF_FFFF);
    btn[3] = 1'b1;
    idle(3);
    btn[3] = 1'b0;
    repeat (6) rd(32'h08, d);
    chk("short_state", d, 32'h0);
    rd(32'h0C, d);
    chk("short_event", d, 32'h0);

    btn[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      rd(32'h08, d);
      if (k == 5) chk("db_state_k5", d, 32'h0);
      if (k == 6) chk("db_state_k6", d, 32'h8);
    end
    rd(32'h0C, d);
    chk("db_event", d, 32'h8);

    wr(32'h10, 32'h8);
    chk("irq_set", 32'(irq), 32'h1);
    wr(32'h0C, 32'h8);
    chk("irq_clr", 32'(irq), 32'h0);

    btn[3] = 1'b0;
    idle(10);
    btn[3] = 1'b1;
    idle(5);
    wr(32'h0C, 32'h8);
    rd(32'h0C, d);
    chk("set_wins", d, 32'h8);
    chk("set_wins_irq", 32'(irq), 32'h1);

    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 15);
        btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      case ($urandom_range(0, 3))
        0: idle(1);
        1: rd(raddr(3'($urandom_range(0, 7))), d);
        2: wr(raddr(3'($urandom_range(0, 7))), $urandom);
        default: wr(raddr(3'd3), $urandom);
      endcase
    end

    btn = '0;
    wr(32'h14, 32'hFFFF_1234);
    wr(32'h18, 32'hFFFF_FFFF);
    idle(24);
    wr(32'h18, 32'h5);
    idle(12);
    wr(32'h1C, $urandom);
    rd(32'h1C, d);
    chk("rsvd_read", d, 32'h0);
    idle(4);

    #2;
    reset_now();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(3);
    rd(32'h00, d);
    chk("led_after_rst", d, 32'h0);
    rd(32'h18, d);
    chk("mask_after_rst", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
